// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word fetches, buffers returned words in a
// small shift FIFO and presents the head instruction with its PC to the core.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus8,
  output logic        InstrValid
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'hE1A0_0000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  logic [1:0]    state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic [CW-1:0] cnt, cnt_nx, wr_idx;
  entry_t        fifo_q  [FIFO_DEPTH];
  entry_t        fifo_nx [FIFO_DEPTH];
  logic          push, pop;
  logic [31:0]   addr_q, instr_q, instr_pc_q, pc8_q;
  logic          req_q, valid_q;
  logic          unused_target_lsbs;

  assign unused_target_lsbs = ^BranchTarget[1:0];

  // Next-state: FSM, fetch pointer and FIFO contents; redirect beats push/pop.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    cnt_nx      = cnt;
    fifo_nx     = fifo_q;
    push        = (state == REQ) && imem_ready && !PCSrc;
    pop         = (cnt != '0) && !Stall && !PCSrc;
    wr_idx      = pop ? (cnt - CW'(1)) : cnt;

    if (PCSrc) begin
      cnt_nx      = '0;
      fetch_pc_nx = {BranchTarget[31:2], 2'b00};
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
          fifo_nx[i] = fifo_q[i+1];
        end
      end
      if (push) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          if (CW'(i) == wr_idx) fifo_nx[i] = '{word: imem_rdata, pc: fetch_pc};
        end
        fetch_pc_nx = fetch_pc + 32'd4;
      end
      cnt_nx = wr_idx + (push ? CW'(1) : CW'(0));
    end

    case (state)
      IDLE: if (!PCSrc && (cnt < DEPTH_C)) state_nx = REQ;
      REQ: begin
        if (PCSrc)           state_nx = imem_ready ? IDLE : DROP;
        else if (imem_ready) state_nx = (cnt_nx < DEPTH_C) ? REQ : IDLE;
      end
      DROP: if (imem_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; imem_addr freezes on the abandoned address in DROP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      cnt        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= NOP;
      instr_pc_q <= 32'd0;
      pc8_q      <= 32'd8;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      cnt        <= cnt_nx;
      fifo_q     <= fifo_nx;
      addr_q     <= (state_nx == DROP) ? addr_q : fetch_pc_nx;
      req_q      <= (state_nx != IDLE);
      instr_q    <= (cnt_nx != '0) ? fifo_nx[0].word : NOP;
      instr_pc_q <= fifo_nx[0].pc;
      pc8_q      <= fifo_nx[0].pc + 32'd8;
      valid_q    <= (cnt_nx != '0);
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign PCPlus8    = pc8_q;
  assign InstrValid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a queue-based fetch model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        Stall = 1'b0;
  logic [31:0] Instr, InstrPC, PCPlus8;
  logic        InstrValid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall),
    .Instr(Instr), .InstrPC(InstrPC), .PCPlus8(PCPlus8), .InstrValid(InstrValid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of buffered {word,pc}, next expected fetch address, pending drop.
  typedef struct packed { logic [31:0] w; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  logic [31:0] exp_pc;
  logic        drop_pend, prev_hold;
  logic [31:0] drop_addr, prev_addr;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_pc = 32'h0; drop_pend = 1'b0; prev_hold = 1'b0;
        drop_addr = 32'h0; prev_addr = 32'h0;
      end else begin
        chk("m_valid", {31'd0, InstrValid}, {31'd0, q.size() != 0});
        chk("m_instr", Instr, (q.size() != 0) ? q[0].w : NOP);
        if (q.size() != 0) begin
          chk("m_pc", InstrPC, q[0].pc);
          chk("m_pc8", PCPlus8, q[0].pc + 32'd8);
        end
        if (drop_pend) begin
          chk("m_drop_req", {31'd0, imem_req}, 32'd1);
          chk("m_drop_addr", imem_addr, drop_addr);
        end else if (imem_req) begin
          chk("m_addr", imem_addr, exp_pc);
        end
        if (prev_hold) begin
          chk("m_hold_req", {31'd0, imem_req}, 32'd1);
          chk("m_hold_addr", imem_addr, prev_addr);
        end
        chk("m_capacity", {31'd0, (q.size() + ((imem_req && !drop_pend) ? 1 : 0)) <= DEPTH}, 32'd1);

        prev_hold = imem_req && !imem_ready;
        prev_addr = imem_addr;
        if (PCSrc) begin
          q.delete();
          if (imem_req && !imem_ready) begin
            if (!drop_pend) begin
              drop_pend = 1'b1;
              drop_addr = exp_pc;
            end
          end else if (imem_req && imem_ready) begin
            drop_pend = 1'b0;
          end
          exp_pc = {BranchTarget[31:2], 2'b00};
        end else begin
          if (q.size() != 0 && !Stall) void'(q.pop_front());
          if (imem_req && imem_ready) begin
            if (drop_pend) drop_pend = 1'b0;
            else begin
              q.push_back('{w: exp_pc ^ K, pc: exp_pc});
              exp_pc = exp_pc + 32'd4;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("wait_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_steady();
    int n = 0;
    while (!(imem_req && InstrValid) && n < 20) begin @(negedge clk); n++; end
    chk("wait_steady", {31'd0, imem_req && InstrValid}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    @(posedge clk); #1 PCSrc = 1'b1; BranchTarget = tgt;
    @(posedge clk); #1 PCSrc = 1'b0;
  endtask

  initial begin
    int xfers;
    // Reset values
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_pc8", PCPlus8, 32'h8);

    // 1: streaming fetch
    @(posedge clk); #1 rst_n = 1'b1;
    wait_req();
    chk("t1_addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("t1_instr0", Instr, 32'hA5A5_A5A5);
    chk("t1_pc0", InstrPC, 32'h0);
    chk("t1_pc8", PCPlus8, 32'h8);
    chk("t1_addr4", imem_addr, 32'h4);
    @(negedge clk);
    chk("t1_instr1", Instr, 32'hA5A5_A5A1);
    chk("t1_addr8", imem_addr, 32'h8);
    @(negedge clk);
    chk("t1_instr2", Instr, 32'hA5A5_A5AD);
    chk("t1_pc2", InstrPC, 32'h8);

    // 2: stall fills FIFO then idles
    Stall = 1'b1;
    do_reset();
    xfers = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) xfers++;
    end
    chk("t2_xfers", 32'(xfers), 32'd2);
    chk("t2_req_idle", {31'd0, imem_req}, 32'd0);
    chk("t2_instr", Instr, 32'hA5A5_A5A5);
    chk("t2_pc", InstrPC, 32'h0);
    @(posedge clk); #1 Stall = 1'b0;
    wait_req();
    chk("t2_resume", imem_addr, 32'h8);

    // 3: redirect while a request waits -> drop
    imem_ready = 1'b0;
    do_reset();
    wait_req();
    chk("t3_addr_w0", imem_addr, 32'h0);
    @(negedge clk); chk("t3_addr_w1", imem_addr, 32'h0);
    @(negedge clk); chk("t3_addr_w2", imem_addr, 32'h0);
    redirect(32'h100);
    @(negedge clk);
    chk("t3_drop_req", {31'd0, imem_req}, 32'd1);
    chk("t3_drop_addr", imem_addr, 32'h0);
    chk("t3_drop_valid", {31'd0, InstrValid}, 32'd0);
    @(posedge clk); #1 imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle_req", {31'd0, imem_req}, 32'd0);
    chk("t3_idle_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    chk("t3_instr", Instr, 32'hA5A5_A4A5);
    chk("t3_pc", InstrPC, 32'h100);

    // 4: redirect coinciding with transfer and pop
    do_reset();
    wait_steady();
    redirect(32'h203);
    @(negedge clk);
    chk("t4_valid", {31'd0, InstrValid}, 32'd0);
    chk("t4_nop", Instr, NOP);
    chk("t4_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_nop2", Instr, NOP);
    @(negedge clk);
    chk("t4_instr", Instr, 32'hA5A5_A7A5);
    chk("t4_pc", InstrPC, 32'h200);

    // 5: address wrap
    redirect(32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    chk("t5_instr", Instr, 32'h5A5A_5A59);
    chk("t5_pc", InstrPC, 32'hFFFF_FFFC);
    chk("t5_pc8", PCPlus8, 32'h4);

    // 6: asynchronous reset mid-request
    wait_steady();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_valid", {31'd0, InstrValid}, 32'd0);
    chk("t6_instr", Instr, NOP);
    chk("t6_pc", InstrPC, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_req();
    chk("t6_restart", imem_addr, 32'h0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
